// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS checker: FSM states, predictor taps and history length.
package lfsr_pkg;

   typedef enum logic [1:0] {
      FILL,
      VERIFY,
      LOCKED
   } state_e;

   localparam int REG_SIZE_DEF = 8;

   localparam int TAP0 = 7;
   localparam int TAP1 = 6;
   localparam int TAP2 = 5;
   localparam int TAP3 = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear wins over an increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the inverted output of the 8-bit LFSR generator:
// fills and verifies history, locks, then flywheels and counts bit errors.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int REG_SIZE    = REG_SIZE_DEF,
   parameter int LOCK_COUNT  = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count,
   output logic             lock_lost
);

   localparam int FILL_W = $clog2(REG_SIZE + 1);
   localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W  = $clog2(WINDOW + 1);
   localparam int WERR_W = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(REG_SIZE - 1);
   localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_COUNT - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] THRESH_LAST = WERR_W'(LOSS_THRESH - 1);

   state_e              state_q, state_d;
   logic [REG_SIZE-1:0] h_q, h_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic                locked_q, err_pulse_q, lock_lost_q;
   logic                err_pulse_d, lock_lost_d;
   logic                loss, win_wrap;

   logic [WIN_W-1:0]    win_cnt;
   logic [WERR_W-1:0]   werr_cnt;

   logic s, p, mis, h_nz, chk_bit, chk_err, win_clr;

   assign s    = ~in_bit;
   assign p    = h_q[TAP0] ^ h_q[TAP1] ^ h_q[TAP2] ^ h_q[TAP3];
   assign mis  = s ^ p;
   assign h_nz = |h_q;

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      fill_d      = fill_q;
      good_d      = good_q;
      err_pulse_d = 1'b0;
      lock_lost_d = 1'b0;
      loss        = 1'b0;
      win_wrap    = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            FILL: begin
               h_d    = {h_q[REG_SIZE-2:0], s};
               fill_d = fill_q + 1'b1;
               if (fill_q == FILL_LAST) begin
                  state_d = VERIFY;
                  fill_d  = '0;
                  good_d  = '0;
               end
            end
            VERIFY: begin
               // Self-sync: the received bit, not the prediction, enters history.
               h_d = {h_q[REG_SIZE-2:0], s};
               if (!mis && h_nz) begin
                  if (good_q == LOCK_LAST) begin
                     state_d = LOCKED;
                     good_d  = '0;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end else begin
                  good_d = '0;
               end
            end
            LOCKED: begin
               // Flywheel: a single corrupted bit cannot propagate into later predictions.
               h_d         = {h_q[REG_SIZE-2:0], p};
               err_pulse_d = mis;
               if (mis && (werr_cnt == THRESH_LAST)) begin
                  loss        = 1'b1;
                  lock_lost_d = 1'b1;
                  state_d     = FILL;
                  h_d         = '0;
                  fill_d      = '0;
                  good_d      = '0;
               end else if (win_cnt == WIN_LAST) begin
                  win_wrap = 1'b1;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         h_q         <= '0;
         fill_q      <= '0;
         good_q      <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         fill_q      <= fill_d;
         good_q      <= good_d;
         locked_q    <= (state_d == LOCKED);
         err_pulse_q <= err_pulse_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   assign chk_bit = in_valid && (state_q == LOCKED);
   assign chk_err = chk_bit && mis;
   assign win_clr = (state_q != LOCKED) || win_wrap || loss;

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk(clk), .rst(rst), .clr(clr_cnt), .inc(chk_err), .cnt_o(err_count)
   );

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk(clk), .rst(rst), .clr(clr_cnt), .inc(chk_bit), .cnt_o(bit_count)
   );

   sat_counter #(.W(WIN_W)) u_win_cnt (
      .clk(clk), .rst(rst), .clr(win_clr), .inc(chk_bit), .cnt_o(win_cnt)
   );

   sat_counter #(.W(WERR_W)) u_werr_cnt (
      .clk(clk), .rst(rst), .clr(win_clr), .inc(chk_err), .cnt_o(werr_cnt)
   );

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker: two instances (16-bit and 4-bit counters) share one
// stimulus stream and are compared every cycle against a queue-based reference model.
module tb_lfsr_checker;

   localparam int LOCK_COUNT  = 16;
   localparam int WINDOW      = 64;
   localparam int LOSS_THRESH = 8;

   localparam int M_FILL   = 0;
   localparam int M_VERIFY = 1;
   localparam int M_LOCKED = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_bit, in_valid, clr_cnt;
   logic        locked, err_pulse, lock_lost;
   logic [15:0] err_count, bit_count;
   logic        locked4, err_pulse4, lock_lost4;
   logic [3:0]  err_count4, bit_count4;

   lfsr_checker dut (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
      .bit_count(bit_count), .lock_lost(lock_lost)
   );

   lfsr_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr_cnt(clr_cnt),
      .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4),
      .bit_count(bit_count4), .lock_lost(lock_lost4)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: history is a queue of stream bits, oldest at index 0.
   bit hq[$];
   int m_mode, m_fill, m_good, m_win, m_werr, m_err, m_bits;
   bit m_locked, m_pulse, m_lost;

   function automatic void model_reset();
      hq.delete();
      repeat (8) hq.push_back(1'b0);
      m_mode = M_FILL; m_fill = 0; m_good = 0; m_win = 0; m_werr = 0;
      m_err = 0; m_bits = 0;
      m_locked = 1'b0; m_pulse = 1'b0; m_lost = 1'b0;
   endfunction

   function automatic void model_push(bit x);
      hq.push_back(x);
      void'(hq.pop_front());
   endfunction

   function automatic void model_step(bit v, bit b, bit clr);
      bit s, p, nz;
      m_pulse = 1'b0;
      m_lost  = 1'b0;
      if (clr) begin
         m_err  = 0;
         m_bits = 0;
      end
      if (v) begin
         s  = ~b;
         p  = hq[0] ^ hq[1] ^ hq[2] ^ hq[3];
         nz = 1'b0;
         foreach (hq[i]) nz |= hq[i];
         if (m_mode == M_FILL) begin
            model_push(s);
            m_fill++;
            if (m_fill == 8) begin
               m_mode = M_VERIFY;
               m_good = 0;
            end
         end else if (m_mode == M_VERIFY) begin
            if (s == p && nz) m_good++;
            else m_good = 0;
            model_push(s);
            if (m_good == LOCK_COUNT) begin
               m_mode = M_LOCKED;
               m_win  = 0;
               m_werr = 0;
            end
         end else begin
            model_push(p);
            if (!clr) m_bits++;
            m_win++;
            if (s != p) begin
               m_pulse = 1'b1;
               if (!clr) m_err++;
               m_werr++;
            end
            if (m_werr == LOSS_THRESH) begin
               m_lost = 1'b1;
               m_mode = M_FILL;
               foreach (hq[i]) hq[i] = 1'b0;
               m_fill = 0; m_good = 0; m_win = 0; m_werr = 0;
            end else if (m_win == WINDOW) begin
               m_win  = 0;
               m_werr = 0;
            end
         end
      end
      m_locked = (m_mode == M_LOCKED);
   endfunction

   function automatic int sat(input int x, input int maxv);
      return (x > maxv) ? maxv : x;
   endfunction

   task automatic compare_all();
      chk_eq("locked",     32'(locked),     32'(m_locked));
      chk_eq("err_pulse",  32'(err_pulse),  32'(m_pulse));
      chk_eq("lock_lost",  32'(lock_lost),  32'(m_lost));
      chk_eq("err_count",  32'(err_count),  32'(sat(m_err, 65535)));
      chk_eq("bit_count",  32'(bit_count),  32'(sat(m_bits, 65535)));
      chk_eq("locked4",    32'(locked4),    32'(m_locked));
      chk_eq("err_pulse4", 32'(err_pulse4), 32'(m_pulse));
      chk_eq("lock_lost4", 32'(lock_lost4), 32'(m_lost));
      chk_eq("err_count4", 32'(err_count4), 32'(sat(m_err, 15)));
      chk_eq("bit_count4", 32'(bit_count4), 32'(sat(m_bits, 15)));
   endtask

   // Generator: s[n] = s[n-8]^s[n-7]^s[n-6]^s[n-5], delivered inverted.
   logic [7:0] g;

   function automatic bit gen_bit();
      bit nb;
      nb = g[7] ^ g[6] ^ g[5] ^ g[4];
      g  = {g[6:0], nb};
      return ~nb;
   endfunction

   task automatic cycle(input bit v, input bit b, input bit clr, input bit r);
      rst      = r;
      in_valid = v;
      in_bit   = b;
      clr_cnt  = clr;
      @(posedge clk);
      if (r) model_reset();
      else model_step(v, b, clr);
      @(negedge clk);
      compare_all();
   endtask

   task automatic send(input bit v, input bit flip, input bit clr);
      bit b;
      if (v) b = gen_bit() ^ flip;
      else b = 1'($urandom_range(0, 1));
      cycle(v, b, clr, 1'b0);
   endtask

   task automatic wait_lock(input string tag, input int max_bits);
      for (int i = 0; i < max_bits && !locked; i++) send(1'b1, 1'b0, 1'b0);
      chk_eq(tag, 32'(locked), 32'd1);
   endtask

   task automatic align_window();
      for (int i = 0; i < WINDOW + 2 && m_win != 0; i++) send(1'b1, 1'b0, 1'b0);
      chk_eq("align", 32'(m_win), 32'd0);
   endtask

   int  pulses, nv, b0;
   bit  lost_seen, ever_locked, v;

   initial begin
      model_reset();
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      chk_eq("rst_locked", 32'(locked), 32'd0);
      chk_eq("rst_errs",   32'(err_count), 32'd0);

      // Clean lock from seed 0x01, then 1000 error-free bits.
      g = 8'h01;
      wait_lock("clean_lock", 24);
      for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, 1'b0);
      chk_eq("clean_errs", 32'(err_count), 32'd0);
      chk_eq("clean_bits", 32'(bit_count), 32'd1000);

      // Single flipped bit.
      pulses = 0;
      send(1'b1, 1'b1, 1'b0);
      pulses += int'(err_pulse);
      for (int i = 0; i < 10; i++) begin
         send(1'b1, 1'b0, 1'b0);
         pulses += int'(err_pulse);
      end
      chk_eq("single_pulses", 32'(pulses), 32'd1);
      chk_eq("single_errs",   32'(err_count), 32'd1);
      chk_eq("single_locked", 32'(locked), 32'd1);

      // Reseed while locked: loss of lock, then relock.
      align_window();
      g = 8'h5A;
      lost_seen = 1'b0;
      for (int i = 0; i < 64 && !lost_seen; i++) begin
         send(1'b1, 1'b0, 1'b0);
         lost_seen = lock_lost;
      end
      chk_eq("loss_seen",   32'(lost_seen), 32'd1);
      chk_eq("loss_locked", 32'(locked), 32'd0);
      wait_lock("relock", 24);

      // Degenerate zero seed never locks.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      g = 8'h00;
      ever_locked = 1'b0;
      for (int i = 0; i < 500; i++) begin
         send(1'b1, 1'b0, 1'b0);
         ever_locked |= locked;
      end
      chk_eq("zero_locked", 32'(ever_locked), 32'd0);
      chk_eq("zero_errs",   32'(err_count), 32'd0);

      // Valid gating with a random seed, then clear coincident with an error.
      g = 8'($urandom_range(1, 255));
      wait_lock("gate_lock", 24);
      b0 = int'(bit_count);
      nv = 0;
      for (int i = 0; i < 200; i++) begin
         v = 1'($urandom_range(0, 1));
         send(v, v && (nv % 20 == 19), 1'b0);
         nv += int'(v);
      end
      chk_eq("gate_bits", 32'(bit_count), 32'(b0 + nv));
      send(1'b1, 1'b1, 1'b1);
      chk_eq("clr_errs",   32'(err_count), 32'd0);
      chk_eq("clr_bits",   32'(bit_count), 32'd0);
      chk_eq("clr_locked", 32'(locked), 32'd1);

      // Spread errors (below loss threshold) to saturate the narrow counters.
      align_window();
      for (int i = 0; i < 200; i++) send(1'b1, (i % 10) == 9, 1'b0);
      chk_eq("sat_err4",   32'(err_count4), 32'd15);
      chk_eq("sat_err16",  32'(err_count), 32'd20);
      chk_eq("sat_locked", 32'(locked), 32'd1);

      // Reset while locked.
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk_eq("mid_rst_locked", 32'(locked), 32'd0);
      chk_eq("mid_rst_pulse",  32'(err_pulse), 32'd0);
      chk_eq("mid_rst_lost",   32'(lock_lost), 32'd0);
      chk_eq("mid_rst_errs",   32'(err_count), 32'd0);
      chk_eq("mid_rst_bits",   32'(bit_count), 32'd0);
      chk_eq("mid_rst_errs4",  32'(err_count4), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
